// File: rtl/clock_divider_fifo_pkg.sv
// Shared defaults and sizing helpers for the divided-clock FIFO block.
package clock_divider_fifo_pkg;

    localparam int DEF_CLOCK_RATE  = 50_000_000;
    localparam int DEF_OUTPUT_RATE = 153_600;
    localparam int DEF_DEPTH       = 64;
    localparam int DEF_WIDTH       = 8;

    // Occupancy needs one extra bit so that "full" (== DEPTH) is representable.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int half_period(input int clock_rate, input int output_rate);
        int h;
        h = clock_rate / (2 * output_rate);
        return (h < 1) ? 1 : h;
    endfunction

endpackage

// File: rtl/clock_divider_fifo_tick.sv
// Square-wave divider: toggles o_clock every HALF cycles and strobes o_tick on each rise.
module clock_divider_tick
    import clock_divider_fifo_pkg::*;
#(
    parameter int CLOCK_RATE  = DEF_CLOCK_RATE,
    parameter int OUTPUT_RATE = DEF_OUTPUT_RATE
) (
    input  logic i_clock,
    input  logic i_reset_n,
    output logic o_clock,
    output logic o_tick
);

    localparam int HALF = half_period(CLOCK_RATE, OUTPUT_RATE);
    localparam int DW   = (HALF > 1) ? $clog2(HALF) : 1;

    logic [DW-1:0] r_count;
    logic          r_clock;
    logic          r_tick;
    logic          w_wrap;

    assign w_wrap = (r_count == DW'(HALF - 1));

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count <= '0;
            r_clock <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_count <= w_wrap ? '0 : r_count + DW'(1);
            r_clock <= w_wrap ? ~r_clock : r_clock;
            // Registered alongside r_clock so the strobe lines up with the first high cycle.
            r_tick  <= w_wrap & ~r_clock;
        end
    end

    assign o_clock = r_clock;
    assign o_tick  = r_tick;

endmodule

// File: rtl/clock_divider_fifo.sv
// Clock divider plus an edge-triggered push/pop FIFO with registered status flags.
module clock_divider_fifo
    import clock_divider_fifo_pkg::*;
#(
    parameter int CLOCK_RATE  = DEF_CLOCK_RATE,
    parameter int OUTPUT_RATE = DEF_OUTPUT_RATE,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int WIDTH       = DEF_WIDTH
) (
    input  logic                          i_clock,
    input  logic                          i_reset_n,
    output logic                          o_clock,
    output logic                          o_tick,
    input  logic                          i_write,
    input  logic [WIDTH-1:0]              i_wdata,
    input  logic                          i_read,
    output logic [WIDTH-1:0]              o_rdata,
    output logic                          o_empty,
    output logic                          o_full,
    output logic [count_width(DEPTH)-1:0] o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             r_empty;
    logic             r_full;
    logic [WIDTH-1:0] r_rdata;
    logic             r_write_q;
    logic             r_read_q;

    logic             w_push_ev;
    logic             w_pop_ev;
    logic             w_do_push;
    logic             w_do_pop;
    logic [CW-1:0]    w_count_next;

    clock_divider_tick #(
        .CLOCK_RATE  (CLOCK_RATE),
        .OUTPUT_RATE (OUTPUT_RATE)
    ) u_div (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .o_clock   (o_clock),
        .o_tick    (o_tick)
    );

    assign w_push_ev = i_write & ~r_write_q;
    assign w_pop_ev  = i_read  & ~r_read_q;
    assign w_do_pop  = w_pop_ev & ~r_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign w_do_push = w_push_ev & (~r_full | w_do_pop);

    always_comb begin
        w_count_next = r_count;
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_write_q <= 1'b0;
            r_read_q  <= 1'b0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_empty   <= 1'b1;
            r_full    <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_write_q <= i_write;
            r_read_q  <= i_read;
            if (w_do_push) r_wptr <= r_wptr + AW'(1);
            if (w_do_pop) begin
                r_rptr  <= r_rptr + AW'(1);
                r_rdata <= r_mem[r_rptr];
            end
            r_count <= w_count_next;
            r_empty <= (w_count_next == '0);
            r_full  <= (w_count_next == CW'(DEPTH));
        end
    end

    // Storage is deliberately not reset; pointers alone define the valid contents.
    always_ff @(posedge i_clock) begin
        if (w_do_push) r_mem[r_wptr] <= i_wdata;
    end

    assign o_rdata = r_rdata;
    assign o_empty = r_empty;
    assign o_full  = r_full;
    assign o_count = r_count;

endmodule

// File: tb/tb_clock_divider_fifo.sv
// Directed and randomized checks of clock_divider_fifo against a queue-based reference model.
module tb_clock_divider_fifo;

    localparam int DEPTH = 64;
    localparam int WIDTH = 8;
    localparam int HALF  = 50_000_000 / (2 * 153_600);

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             w     = 1'b0;
    logic             r     = 1'b0;
    logic [WIDTH-1:0] wd    = '0;
    logic             o_clock, o_tick, o_empty, o_full;
    logic [WIDTH-1:0] o_rdata;
    logic [6:0]       o_count;

    int tests = 0;
    int fails = 0;
    int cyc_n = 0;

    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_rdata = '0;
    logic             m_pw = 1'b0;
    logic             m_pr = 1'b0;

    clock_divider_fifo dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .o_clock   (o_clock),
        .o_tick    (o_tick),
        .i_write   (w),
        .i_wdata   (wd),
        .i_read    (r),
        .o_rdata   (o_rdata),
        .o_empty   (o_empty),
        .o_full    (o_full),
        .o_count   (o_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc_n);
        end
    endtask

    // One clock with the given inputs; the model follows plain queue semantics.
    task automatic step(input logic iw, input logic [WIDTH-1:0] iwd, input logic ir);
        logic push_ev, pop_ev;
        w = iw; wd = iwd; r = ir;
        @(posedge clk);
        #1;
        cyc_n++;
        push_ev = iw && !m_pw;
        pop_ev  = ir && !m_pr;
        if (pop_ev && q.size() > 0) m_rdata = q.pop_front();
        if (push_ev && q.size() < DEPTH) q.push_back(iwd);
        m_pw = iw;
        m_pr = ir;
        check("count", 32'(o_count), 32'(q.size()));
        check("empty", 32'(o_empty), 32'(q.size() == 0));
        check("full",  32'(o_full),  32'(q.size() == DEPTH));
        check("rdata", 32'(o_rdata), 32'(m_rdata));
        check("oclk",  32'(o_clock), 32'((cyc_n / HALF) % 2));
        check("tick",  32'(o_tick),  32'((cyc_n % HALF == 0) && ((cyc_n / HALF) % 2 == 1)));
    endtask

    task automatic do_reset(input logic iw, input logic [WIDTH-1:0] iwd, input logic ir);
        rst_n = 1'b0;
        w = iw; wd = iwd; r = ir;
        #1;
        check("rst_count", 32'(o_count), 0);
        check("rst_empty", 32'(o_empty), 1);
        check("rst_full",  32'(o_full),  0);
        check("rst_rdata", 32'(o_rdata), 0);
        check("rst_oclk",  32'(o_clock), 0);
        check("rst_tick",  32'(o_tick),  0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        m_rdata = '0;
        m_pw = 1'b0;
        m_pr = 1'b0;
        cyc_n = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc_n);
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] v3 [3];
        v3[0] = 8'h11; v3[1] = 8'h22; v3[2] = 8'h33;

        @(posedge clk);
        #1;
        do_reset(1'b0, '0, 1'b0);

        // Divider alone: rises at 162 and 486, falls at 324.
        for (int i = 0; i < 700; i++) begin
            step(1'b0, '0, 1'b0);
            if (cyc_n == 162 || cyc_n == 486) check("rise_tick", 32'(o_tick), 1);
            if (cyc_n == 324) check("fall_clk", 32'(o_clock), 0);
        end

        // Three stretched pushes, then three pops in order.
        for (int i = 0; i < 3; i++) begin
            repeat (3) step(1'b1, v3[i], 1'b0);
            step(1'b0, v3[i], 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b1);
            check("fifo_order", 32'(o_rdata), 32'(v3[i]));
            step(1'b0, '0, 1'b0);
        end
        check("drained_empty", 32'(o_empty), 1);

        // Held write is one event.
        repeat (10) step(1'b1, 8'hA5, 1'b0);
        step(1'b0, 8'hA5, 1'b0);
        check("held_write", 32'(o_count), 1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);

        // Fill past capacity, then drain across the wrapped pointers.
        for (int i = 0; i <= DEPTH; i++) begin
            step(1'b1, 8'(i), 1'b0);
            step(1'b0, 8'(i), 1'b0);
            if (i == DEPTH - 1) check("full_at_64", 32'(o_full), 1);
        end
        check("count_64", 32'(o_count), DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, '0, 1'b1);
            check("drain_order", 32'(o_rdata), 32'(i));
            step(1'b0, '0, 1'b0);
        end
        check("drain_empty", 32'(o_empty), 1);

        // Simultaneous push/pop with one entry.
        step(1'b1, 8'h07, 1'b0);
        step(1'b0, 8'h07, 1'b0);
        step(1'b1, 8'h08, 1'b1);
        check("simul_rdata", 32'(o_rdata), 32'h07);
        check("simul_count", 32'(o_count), 1);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);
        check("simul_next", 32'(o_rdata), 32'h08);
        step(1'b0, '0, 1'b0);

        // Pop on empty keeps o_rdata; reset mid-operation clears occupancy.
        step(1'b1, 8'h5A, 1'b0);
        step(1'b0, 8'h5A, 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);
        check("empty_pop_hold", 32'(o_rdata), 32'h5A);
        step(1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'(8'hC0 + i), 1'b0);
            step(1'b0, '0, 1'b0);
        end
        check("five_stored", 32'(o_count), 5);

        // Write already high at release is an event on the first cycle.
        do_reset(1'b1, 8'h3C, 1'b0);
        step(1'b1, 8'h3C, 1'b0);
        check("release_push", 32'(o_count), 1);
        step(1'b0, '0, 1'b0);

        // Random traffic: write-heavy, then read-heavy, then balanced.
        for (int i = 0; i < 3000; i++) begin
            logic rw, rr;
            if (i < 1000) begin
                rw = ($urandom_range(0, 3) != 0);
                rr = ($urandom_range(0, 3) == 0);
            end else if (i < 2000) begin
                rw = ($urandom_range(0, 3) == 0);
                rr = ($urandom_range(0, 3) != 0);
            end else begin
                rw = 1'($urandom_range(0, 1));
                rr = 1'($urandom_range(0, 1));
            end
            step(rw, 8'($urandom), rr);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/clock_divider_fifo.md
CLOCK_DIVIDER_FIFO -- requirements
Module: clock_divider_fifo

Interface
REQ-001 Parameter CLOCK_RATE, default 50000000: input clock frequency in Hz.
REQ-002 Parameter OUTPUT_RATE, default 153600: divided clock frequency in Hz (9600 baud x16).
REQ-003 Parameter DEPTH, default 64: FIFO entries; power of two, >=2.
REQ-004 Parameter WIDTH, default 8: FIFO data width in bits.
REQ-005 Port i_clock, input, 1: the single system clock; all logic on its rising edge.
REQ-006 Port i_reset_n, input, 1: reset; asynchronous, active-low.
REQ-007 Port o_clock, output, 1: divided square-wave clock.
REQ-008 Port o_tick, output, 1: one-cycle strobe on each o_clock rising transition.
REQ-009 Port i_write, input, 1: push request; rising-edge sensitive.
REQ-010 Port i_wdata, input, WIDTH: push data.
REQ-011 Port i_read, input, 1: pop request; rising-edge sensitive.
REQ-012 Port o_rdata, output, WIDTH: registered head data from the last pop.
REQ-013 Port o_empty, output, 1: high when the FIFO holds 0 entries.
REQ-014 Port o_full, output, 1: high when the FIFO holds DEPTH entries.
REQ-015 Port o_count, output, clog2(DEPTH)+1: current occupancy.

Function
REQ-016 Divider half-period N = CLOCK_RATE/(2*OUTPUT_RATE), integer floor, clamped to a minimum of 1; N=162 at defaults.
REQ-017 Divider counter runs 0..N-1; at N-1 it wraps to 0 and o_clock toggles; output period is 2N cycles (324 at defaults).
REQ-018 o_tick is high for exactly the one cycle in which o_clock is 1 following a 0->1 toggle.
REQ-019 FIFO registers i_write and i_read each cycle.
REQ-020 A push event is i_write=1 with the previous registered value 0; a pop event is i_read=1 with the previous registered value 0.
REQ-021 Holding i_write or i_read high for many cycles produces exactly one event.
REQ-022 On a push event with the FIFO not full: i_wdata is stored at the write pointer, the pointer advances mod DEPTH, and o_count increments.
REQ-023 On a push event with the FIFO full: the push is dropped and the contents are unchanged.
REQ-024 On a pop event with the FIFO not empty: the head entry is loaded into o_rdata at that clock edge, the read pointer advances mod DEPTH, and o_count decrements.
REQ-025 Popped data is valid on o_rdata from the cycle after the edge where i_read is first sampled high.
REQ-026 On a pop event with the FIFO empty: the pop is ignored and o_rdata holds its value.
REQ-027 Simultaneous push and pop events with the FIFO non-empty: both are performed and o_count is unchanged.
REQ-028 Simultaneous push and pop events with the FIFO empty: only the push is performed.
REQ-029 Simultaneous push and pop events with the FIFO full: both are performed.
REQ-030 o_empty, o_full and o_count are registered and reflect each event on the following cycle.
REQ-031 Data order is strictly first-in first-out across pointer wrap-around.

Reset
REQ-032 While i_reset_n=0: divider count=0, o_clock=0, o_tick=0, FIFO pointers=0, o_count=0, o_empty=1, o_full=0, o_rdata=0, and the registered i_write/i_read values are 0.
REQ-033 Asserting reset mid-operation discards all stored entries immediately; storage RAM contents need not be cleared.
REQ-034 Because the registered i_write/i_read values reset to 0, an i_write or i_read already high at reset release counts as an event on the first active cycle.

Structure
REQ-035 A shared package holds the default constants (CLOCK_RATE, baud x16 rate, DEPTH, WIDTH) and the clog2-based count-width function.
REQ-036 The divider is the one natural sub-module, named clock_divider_tick; the FIFO logic resides in the top level.

Verification
REQ-037 Scenario: reset, then run 700 cycles at defaults -> o_clock rises at cycles 162 and 486 and falls at cycle 324; o_tick is high only at those rising cycles.
REQ-038 Scenario: push 0x11, 0x22, 0x33 with a 3-cycle-high pulse each, then pop 3 times -> o_rdata = 0x11, 0x22, 0x33 one cycle after each read edge; o_empty=1 at the end.
REQ-039 Scenario: hold i_write high for 10 cycles with i_wdata=0xA5 -> o_count=1.
REQ-040 Scenario: push 65 entries (0..64) -> o_full=1 after 64 pushes; value 64 is dropped; popping all returns 0..63 in order.
REQ-041 Scenario: with count=1 (head 0x07), raise i_write (0x08) and i_read on the same cycle -> o_rdata=0x07 and o_count stays 1; next pop returns 0x08.
REQ-042 Scenario: pop when empty with o_rdata=0x5A -> o_rdata stays 0x5A; then assert reset with 5 entries stored -> o_count=0, o_empty=1, o_rdata=0.
